// File: rtl/xmr_probe_arbiter.sv
// xmr_probe_arbiter: round-robin capture of port-punched probe signals into a
// single valid/ready sample stream.
// Optional feature macro: XMR_PROBE_TIMEOUT_EN -- when defined, a held sample
// that is not accepted within TIMEOUT cycles is dropped and counted.
module xmr_probe_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   probe_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N_REQ)-1:0]  out_id,
  output logic [DATA_W-1:0]         out_data,
  output logic                      drop_pulse,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] sel;
  logic            sel_vld;
  logic            cap;
  logic            tmo;

  // Reject out-of-range configurations at elaboration
  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 2) begin : g_param_check
    $error("xmr_probe_arbiter: parameter out of range");
  end

  // Round-robin search starting one past the last served requester
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!sel_vld && req[ID_W'((32'(last_id) + 32'd1 + off) % N_REQ)]) begin
        sel     = ID_W'((32'(last_id) + 32'd1 + off) % N_REQ);
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state and grant; grant is the capture strobe of the IDLE cycle
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          cap        = 1'b1;
          grant[sel] = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready || tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      cap     = 1'b0;
      grant   = '0;
    end
  end

  // State, captured sample and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      last_id   <= ID_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == HOLD);
      if (cap) begin
        out_id   <= sel;
        out_data <= probe_data[32'(sel) * DATA_W +: DATA_W];
      end
      // Leaving HOLD means the held id was served (transferred or dropped)
      if (state_q == HOLD && state_d == IDLE) begin
        last_id <= out_id;
      end
    end
  end

`ifdef XMR_PROBE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;

  // HOLD wait counter; zero in the first HOLD cycle
  always_ff @(posedge clk) begin
    if (rst || state_q != HOLD) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign tmo = (state_q == HOLD) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Drop reporting; a same-cycle transfer wins over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      drop_pulse <= tmo && !out_ready;
      if (tmo && !out_ready && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`else
  assign tmo        = 1'b0;
  assign drop_pulse = 1'b0;
  assign drop_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_xmr_probe_arbiter.sv
// Directed self-checking bench for xmr_probe_arbiter (N_REQ=4, DATA_W=8).
module tb_xmr_probe_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] probe_data;
  logic [3:0]  grant;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [7:0]  out_data;
  logic        drop_pulse;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  xmr_probe_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .probe_data (probe_data),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_data   (out_data),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns shortly after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int bad;
  int vcnt;
  int pcnt;

  initial begin
    rst = 1'b1; req = '0; probe_data = '0; out_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_dpulse", 32'(drop_pulse), 32'd0);
    chk("rst_dcnt", 32'(drop_cnt), 32'd0);

    // Single capture of requester 2 with immediate accept
    rst = 1'b0; req = 4'b0100; probe_data = 32'h33A5_2211; out_ready = 1'b1;
    #1 chk("t1_grant", 32'(grant), 32'h4);
    tick();
    req = '0;
    #1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_id", 32'(out_id), 32'd2);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_nogrant", 32'(grant), 32'd0);
    tick();
    #1 chk("t1_idle", 32'(out_valid), 32'd0);

    // All requesters held: rotation 0,1,2,3,0 starting from reset priority
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
      tick();
      #1;
      chk("rr_hold_grant", 32'(grant), 32'd0);
      chk("rr_id", 32'(out_id), 32'(i % 4));
      tick();
    end
    req = '0;

    // Capture id 1 and hold it while the probe and requests keep moving
    req = 4'b0010; probe_data = 32'h0000_5A00; out_ready = 1'b0;
    #1 chk("t3_grant", 32'(grant), 32'h2);
    tick();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      probe_data[15:8] = 8'(8'h60 + k);
      req = 4'b1111;
      #1;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || out_id !== 2'd1 || grant !== 4'b0000) bad++;
      tick();
    end
    chk("t3_hold_stable", 32'(bad), 32'd0);
    out_ready = 1'b1; req = '0;
    #1 chk("t3_xfer_data", 32'(out_data), 32'h5A);
    tick();
    #1;
    chk("t3_after_xfer", 32'(out_valid), 32'd0);
    chk("t3_no_grant", 32'(grant), 32'd0);

    // out_ready while idle does nothing
    tick(); tick();
    #1 chk("idle_ready", 32'(out_valid), 32'd0);

    // Reset in HOLD discards the sample and restores requester-0 priority
    out_ready = 1'b0; req = 4'b0100; probe_data = 32'h44C3_2211;
    #1 chk("t4_grant", 32'(grant), 32'h4);
    tick();
    rst = 1'b1; out_ready = 1'b1; req = '0;
    #1 chk("t4_held", 32'(out_data), 32'hC3);
    tick();
    rst = 1'b0; out_ready = 1'b0; req = 4'b1001;
    #1;
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_data", 32'(out_data), 32'd0);
    chk("t4_grant0", 32'(grant), 32'h1);
    tick();
    #1;
    chk("t4_id", 32'(out_id), 32'd0);
    chk("t4_data0", 32'(out_data), 32'h11);

    // Sparse requests: search wraps from last_id+1 past N_REQ-1
    out_ready = 1'b1;
    tick();
    #1 chk("wrap_grant3", 32'(grant), 32'h8);
    tick();
    #1 chk("wrap_id3", 32'(out_id), 32'd3);
    tick();
    #1 chk("wrap_grant0", 32'(grant), 32'h1);
    req = '0;
    tick(); tick();

`ifdef XMR_PROBE_TIMEOUT_EN
    // Unaccepted sample is held 16 cycles then dropped and counted
    req = 4'b0001; probe_data = 32'h0000_0055; out_ready = 1'b0;
    tick();
    req = '0;
    vcnt = 0; pcnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid === 1'b1) vcnt++;
      if (drop_pulse === 1'b1) pcnt++;
      tick();
    end
    chk("to_valid_cycles", 32'(vcnt), 32'd16);
    chk("to_pulse_cycles", 32'(pcnt), 32'd1);
    chk("to_dcnt1", 32'(drop_cnt), 32'd1);
    req = 4'b0001;
    repeat (17 * 300) tick();
    #1 chk("to_dcnt_sat", 32'(drop_cnt), 32'd255);
    req = '0;
    tick(); tick();
`else
    // Without the timeout the sample waits indefinitely
    req = 4'b0100; probe_data = 32'h007E_0000; out_ready = 1'b0;
    tick();
    req = '0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (out_valid !== 1'b1 || drop_cnt !== 8'd0 || drop_pulse !== 1'b0) bad++;
    end
    chk("nto_hold", 32'(bad), 32'd0);
    chk("nto_data", 32'(out_data), 32'h7E);
    out_ready = 1'b1;
    tick();
    #1 chk("nto_xfer", 32'(out_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xmr_probe_arbiter.md
XMR_PROBE_ARBITER -- requirements
Module: xmr_probe_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of probe requesters (2..16).
REQ-002 SHALL have parameter DATA_W, default 8: width of each probed signal.
REQ-003 SHALL have parameter TIMEOUT, default 16: HOLD-state wait limit in cycles (>=2); used only under REQ-027.
REQ-004 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have req  input  N_REQ  per-requester capture request, level.
REQ-007 SHALL have probe_data  input  N_REQ*DATA_W  port-punched internal signals; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have grant  output  N_REQ  one-hot capture pulse to the selected requester.
REQ-009 SHALL have out_valid  output  1  captured sample available.
REQ-010 SHALL have out_ready  input  1  consumer accepts the sample.
REQ-011 SHALL have out_id  output  clog2(N_REQ)  index of the captured requester.
REQ-012 SHALL have out_data  output  DATA_W  captured sample.
REQ-013 SHALL have drop_pulse  output  1  one-cycle pulse when a sample is discarded on timeout.
REQ-014 SHALL have drop_cnt  output  8  saturating count of discarded samples.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, HOLD.
REQ-016 IDLE with req != 0: SHALL select one requester round-robin, starting the search at (last_id+1) mod N_REQ and wrapping at N_REQ-1 -> 0.
REQ-017 In that IDLE cycle: SHALL assert grant[sel] for exactly one cycle, register probe_data slice sel into out_data and sel into out_id, and enter HOLD.
REQ-018 Latency: req sampled in cycle t SHALL give out_valid=1 in cycle t+1.
REQ-019 IDLE with req == 0: SHALL stay IDLE with grant=0 and out_valid=0.
REQ-020 HOLD: SHALL keep out_valid=1 with out_data and out_id stable until the transfer.
REQ-021 Transfer when out_valid and out_ready are both 1: SHALL set last_id=out_id, clear out_valid next cycle, and return to IDLE; maximum throughput one sample per 2 cycles.
REQ-022 In HOLD: SHALL issue no grant, and req changes SHALL NOT affect out_data or out_id.
REQ-023 A req dropped before it is granted SHALL be ignored and leave no state.
REQ-024 With all N_REQ requesters held high, grants SHALL rotate 0,1,..,N_REQ-1,0 with no starvation.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force, on the next cycle: state=IDLE, out_valid=0, grant=0, out_id=0, out_data=0, drop_pulse=0, drop_cnt=0, and last_id=N_REQ-1 so requester 0 has top priority.
REQ-026a rst=1 during HOLD SHALL discard the held sample without a transfer; rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-027 Macro XMR_PROBE_TIMEOUT_EN defined: SHALL run a HOLD wait counter that clears on HOLD entry.
REQ-027a If no transfer occurs by the TIMEOUT-th cycle of HOLD, that cycle SHALL be the last with out_valid=1.
REQ-027b On timeout, the next cycle SHALL have out_valid=0, drop_pulse=1, drop_cnt+=1 (saturating at 255), state=IDLE, and last_id=dropped id.
REQ-027c A transfer in the TIMEOUT-th cycle SHALL win over the timeout.
REQ-028 Macro XMR_PROBE_TIMEOUT_EN undefined: SHALL have no counter; HOLD waits indefinitely; drop_pulse and drop_cnt tied to 0.

Verification
REQ-029 Reset, then req=4'b0100 with probe slice 2 = 8'hA5 and out_ready=1 -> grant=4'b0100 one cycle; next cycle out_valid=1, out_id=2, out_data=8'hA5; then IDLE.
REQ-030 req=4'b1111 held, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001 on alternate cycles.
REQ-031 Capture id 1 with out_ready=0 for 5 cycles, probe slice 1 changing every cycle -> out_data holds the captured value; transfer on cycle 6; no grant during HOLD.
REQ-032 rst=1 asserted in HOLD -> next cycle out_valid=0, out_data=0; req=4'b1001 then grants requester 0.
REQ-033 With XMR_PROBE_TIMEOUT_EN, TIMEOUT=16, out_ready=0 -> out_valid high exactly 16 cycles, drop_pulse one cycle, drop_cnt=1; 300 drops -> drop_cnt=255.
REQ-034 Without XMR_PROBE_TIMEOUT_EN, out_ready=0 for 1000 cycles -> out_valid stays 1; drop_cnt stays 0.
